// File: rtl/mem_pkg.sv
// Shared parameters and address helpers for the 64x16 banked memory.
// Bank select is the address MSB; the remaining bits index within a bank.
package mem_pkg;

   localparam int DATA_W     = 16;
   localparam int ADDR_W     = 6;
   localparam int BANK_AW    = 5;
   localparam int DEPTH      = 64;
   localparam int BANK_DEPTH = 32;

   typedef enum logic {
      BANK_LO = 1'b0,
      BANK_HI = 1'b1
   } bank_t;

   function automatic bank_t bank_of(input logic [ADDR_W-1:0] addr);
      return bank_t'(addr[ADDR_W-1]);
   endfunction

   function automatic logic [BANK_AW-1:0] local_addr(input logic [ADDR_W-1:0] addr);
      return addr[BANK_AW-1:0];
   endfunction

endpackage

// File: rtl/dpram_32x16.sv
// 32x16 simple dual-port RAM bank: one write port, one registered read-first
// read port, all contents and the output cleared by asynchronous reset.
module dpram_32x16
   import mem_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               wr,
   input  logic [BANK_AW-1:0] waddr,
   input  logic [DATA_W-1:0]  d_in,
   input  logic               rd,
   input  logic [BANK_AW-1:0] raddr,
   output logic [DATA_W-1:0]  d_out
);

   logic [DATA_W-1:0] mem [BANK_DEPTH];

   // Storage array; cleared as a whole so unwritten words read back as zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < BANK_DEPTH; i++) begin
            mem[i] <= {DATA_W{1'b0}};
         end
      end else if (wr) begin
         mem[waddr] <= d_in;
      end
   end

   // Read register; samples the pre-edge array contents, giving read-first collisions.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d_out <= {DATA_W{1'b0}};
      end else if (rd) begin
         d_out <= mem[raddr];
      end
   end

endmodule

// File: rtl/mem_64.sv
// 64x16 simple dual-port RAM built from two 32x16 banks selected by the
// address MSB, with a registered bank select steering the output mux.
module mem_64
   import mem_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              wr,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] d_in,
   input  logic              rd,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] d_out
);

   logic               wr_lo;
   logic               wr_hi;
   logic [DATA_W-1:0]  q_lo;
   logic [DATA_W-1:0]  q_hi;
   bank_t              rsel;
   logic [BANK_AW-1:0] wa_loc;
   logic [BANK_AW-1:0] ra_loc;

   assign wa_loc = local_addr(waddr);
   assign ra_loc = local_addr(raddr);

   // Write-enable decode: only the addressed bank sees the write.
   always_comb begin
      wr_lo = 1'b0;
      wr_hi = 1'b0;
      case (bank_of(waddr))
         BANK_LO: wr_lo = wr;
         BANK_HI: wr_hi = wr;
         default: begin
            wr_lo = 1'b0;
            wr_hi = 1'b0;
         end
      endcase
   end

   // Bank select travels with the read so the mux matches the bank register contents.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsel <= BANK_LO;
      end else if (rd) begin
         rsel <= bank_of(raddr);
      end
   end

   dpram_32x16 u_bank_lo (
      .clk   (clk),
      .rst   (rst),
      .wr    (wr_lo),
      .waddr (wa_loc),
      .d_in  (d_in),
      .rd    (rd),
      .raddr (ra_loc),
      .d_out (q_lo)
   );

   dpram_32x16 u_bank_hi (
      .clk   (clk),
      .rst   (rst),
      .wr    (wr_hi),
      .waddr (wa_loc),
      .d_in  (d_in),
      .rd    (rd),
      .raddr (ra_loc),
      .d_out (q_hi)
   );

   // Output mux between two registered sources; both inputs and select are flops.
   always_comb begin
      d_out = {DATA_W{1'b0}};
      case (rsel)
         BANK_LO: d_out = q_lo;
         BANK_HI: d_out = q_hi;
         default: d_out = {DATA_W{1'b0}};
      endcase
   end

endmodule

// File: tb/tb_mem_64.sv
// Directed self-checking bench for mem_64 with hand-computed expectations.
module tb_mem_64;

   logic        clk;
   logic        rst;
   logic        wr;
   logic [5:0]  waddr;
   logic [15:0] d_in;
   logic        rd;
   logic [5:0]  raddr;
   logic [15:0] d_out;

   int n_cmp = 0;
   int n_err = 0;

   mem_64 dut (
      .clk   (clk),
      .rst   (rst),
      .wr    (wr),
      .waddr (waddr),
      .d_in  (d_in),
      .rd    (rd),
      .raddr (raddr),
      .d_out (d_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input logic w, input logic [5:0] wa, input logic [15:0] wd,
                       input logic r, input logic [5:0] ra);
      wr = w; waddr = wa; d_in = wd; rd = r; raddr = ra;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] exp);
      n_cmp++;
      assert (d_out === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, d_out, exp);
      end
   endtask

   initial begin
      rst = 1'b1; wr = 1'b0; waddr = 6'h00; d_in = 16'h0000; rd = 1'b1; raddr = 6'h01;
      #1;
      chk("reset_t0", 16'h0000);
      @(posedge clk); #1;
      chk("reset_rd_held", 16'h0000);
      rst = 1'b0;

      // reads of unwritten words after release
      step(1'b0, 6'h00, 16'h0000, 1'b1, 6'h00); chk("rd_00_empty", 16'h0000);
      step(1'b0, 6'h00, 16'h0000, 1'b1, 6'h20); chk("rd_20_empty", 16'h0000);
      step(1'b0, 6'h00, 16'h0000, 1'b1, 6'h3F); chk("rd_3F_empty", 16'h0000);

      // bank 0 write/read
      step(1'b1, 6'h01, 16'hADCA, 1'b0, 6'h00);
      step(1'b1, 6'h06, 16'h5767, 1'b0, 6'h00);
      step(1'b0, 6'h00, 16'h0000, 1'b1, 6'h01); chk("rd_01", 16'hADCA);
      step(1'b0, 6'h00, 16'h0000, 1'b1, 6'h06); chk("rd_06", 16'h5767);

      // bank boundaries and aliasing
      step(1'b1, 6'h33, 16'hA7CD, 1'b0, 6'h00);
      step(1'b1, 6'h1F, 16'hA23D, 1'b0, 6'h00);
      step(1'b0, 6'h00, 16'h0000, 1'b1, 6'h33); chk("rd_33", 16'hA7CD);
      step(1'b0, 6'h00, 16'h0000, 1'b1, 6'h1F); chk("rd_1F", 16'hA23D);
      step(1'b0, 6'h00, 16'h0000, 1'b1, 6'h13); chk("rd_13_noalias", 16'h0000);
      step(1'b0, 6'h00, 16'h0000, 1'b1, 6'h21); chk("rd_21_noalias", 16'h0000);
      step(1'b0, 6'h00, 16'h0000, 1'b1, 6'h3F); chk("rd_3F_noalias", 16'h0000);

      // read-first collision
      step(1'b1, 6'h1F, 16'h1234, 1'b1, 6'h1F); chk("collide_old", 16'hA23D);
      step(1'b0, 6'h00, 16'h0000, 1'b1, 6'h1F); chk("collide_new", 16'h1234);

      // hold while writing
      step(1'b0, 6'h00, 16'h0000, 1'b1, 6'h06); chk("pre_hold", 16'h5767);
      step(1'b1, 6'h33, 16'hBEEF, 1'b0, 6'h33); chk("hold_1", 16'h5767);
      step(1'b0, 6'h00, 16'h0000, 1'b0, 6'h20); chk("hold_2", 16'h5767);
      step(1'b0, 6'h00, 16'h0000, 1'b0, 6'h01); chk("hold_3", 16'h5767);
      step(1'b0, 6'h00, 16'h0000, 1'b1, 6'h33); chk("rd_33_beef", 16'hBEEF);

      // concurrent write and read to different banks
      step(1'b1, 6'h02, 16'h1111, 1'b1, 6'h33); chk("conc_rd_33", 16'hBEEF);
      step(1'b0, 6'h00, 16'h0000, 1'b1, 6'h02); chk("conc_rd_02", 16'h1111);

      // mid-operation asynchronous reset
      step(1'b1, 6'h10, 16'hCAFE, 1'b1, 6'h01); chk("burst_rd_01", 16'hADCA);
      #2 rst = 1'b1;
      #1 chk("async_rst", 16'h0000);
      step(1'b1, 6'h05, 16'hFFFF, 1'b1, 6'h33); chk("rst_held", 16'h0000);
      rst = 1'b0;
      step(1'b0, 6'h00, 16'h0000, 1'b1, 6'h01); chk("post_01", 16'h0000);
      step(1'b0, 6'h00, 16'h0000, 1'b1, 6'h06); chk("post_06", 16'h0000);
      step(1'b0, 6'h00, 16'h0000, 1'b1, 6'h1F); chk("post_1F", 16'h0000);
      step(1'b0, 6'h00, 16'h0000, 1'b1, 6'h33); chk("post_33", 16'h0000);
      step(1'b0, 6'h00, 16'h0000, 1'b1, 6'h02); chk("post_02", 16'h0000);
      step(1'b0, 6'h00, 16'h0000, 1'b1, 6'h10); chk("post_10", 16'h0000);
      step(1'b0, 6'h00, 16'h0000, 1'b1, 6'h05); chk("post_05_discard", 16'h0000);

      // first edge after release is usable
      step(1'b1, 6'h3E, 16'h0F0F, 1'b0, 6'h00);
      step(1'b0, 6'h00, 16'h0000, 1'b1, 6'h3E); chk("rd_3E", 16'h0F0F);
      step(1'b0, 6'h00, 16'h0000, 1'b1, 6'h1E); chk("rd_1E_noalias", 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_64.md
# mem_64

64-word × 16-bit simple dual-port RAM with one write port and one read port on a single clock. It is built from two 32×16 DPRAM banks, and the MSB of each address selects the bank. It serves as a general-purpose register-file or buffer memory where one agent writes while another reads.

## Interface
- DATA_W, 16, word width (fixed for this block)
- ADDR_W, 6, address width; depth = 2^ADDR_W = 64
- BANK_AW, 5, per-bank address width; bank depth 32

- clk  in  1  rising-edge clock for all state
- rst  in  1  reset; asynchronous, active-high
- wr  in  1  write enable, sampled on rising clk
- waddr  in  6  write address
- d_in  in  16  write data
- rd  in  1  read enable, sampled on rising clk
- raddr  in  6  read address
- d_out  out  16  registered read data

## Operation
- Bank select: addr[5]=0 → bank 0 (words 0–31); addr[5]=1 → bank 1 (words 32–63).
- Bank-local address is addr[4:0].
- Write: on rising clk with wr=1, mem[waddr] ← d_in.
  - Only the selected bank receives its write enable; the other bank is untouched.
- Read: on rising clk with rd=1, both banks may be addressed with raddr[4:0].
  - raddr[5] is registered alongside the read.
  - d_out = the registered bank-select output mux of the two bank outputs.
- rd=0: d_out holds its last value.
  - The registered bank select also holds, so d_out is stable.
- Reset (rst=1, any time, independent of clk):
  - d_out → 16'h0000.
  - All 64 words → 16'h0000.
  - Registered bank select → 0.
- Reset takes effect immediately, including mid-write or mid-read. Writes or reads presented while rst=1 are discarded.
- After reset, reads of unwritten words return 16'h0000.
- Simultaneous wr and rd to the same address in the same cycle are read-first: d_out gets the old contents and the new data is stored. A read of that address on the next cycle returns the new data.
- Simultaneous wr and rd to different addresses or banks are fully independent.
- Addresses cover 0–63 exactly; no out-of-range case exists.

## Timing
- Write latency: data is stored at the rising edge where wr=1 and is visible to a read issued on the following edge.
- Read latency: 1 cycle. raddr and rd sampled at edge N produce d_out valid just after edge N; it is stable for the whole cycle N→N+1.
- No handshake and no stalls: one write and one read can be accepted every cycle.
- Reset release: the first edge with rst=0 may perform a write or read.

## Structure
- Shared package `mem_pkg`: DATA_W, ADDR_W, BANK_AW, DEPTH=64, BANK_DEPTH=32.
- Sub-module `dpram_32x16`, instantiated twice. Its ports:
  - clk, rst (async active-high clear of contents and output)
  - wr, waddr[4:0], d_in[15:0]
  - rd, raddr[4:0], d_out[15:0]
  - It contains the registered read and read-first behaviour.
- The top level holds:
  - write-enable decode wr & (waddr[5]==bank)
  - the registered raddr[5]
  - the 2:1 output mux.
- The registered raddr[5] updates only when rd=1 and is cleared by rst.

## Test plan
- Reset: assert rst with rd=1 at raddr 0x01 → d_out=0000 during reset. After release, reads of 0x00, 0x20 and 0x3F → 0000.
- Bank 0 write/read: write 0x01=ADCA and 0x06=5767, then read 0x01 and 0x06 → ADCA and 5767, each one cycle after the read edge.
- Bank boundaries: write 0x33=A7CD and 0x1F=A23D.
  - Read 0x33 → A7CD; read 0x1F → A23D.
  - Read 0x13 → 0000 (no alias between banks).
- Read-first collision: 0x1F holds A23D; wr 0x1F=1234 and rd 0x1F in the same cycle → d_out=A23D. Next read of 0x1F → 1234.
- Hold and concurrency: rd=0 for 3 cycles while writing 0x33=BEEF → d_out unchanged. Then read 0x33 → BEEF.
- Mid-operation reset: assert rst asynchronously between edges during a write/read burst.
  - d_out=0000 immediately.
  - After release, all previously written addresses read 0000.
